// File: rtl/imul_pipe.sv
// Pipelined integer multiplier: signed/unsigned/mixed low and high products plus a
// 32-bit sign-extending mode, with x86-style flags, tag, stall (clkEn) and flush.
module imul_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 3,
    parameter int TAG_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_vld,
    output logic [WIDTH-1:0] Res,
    output logic [5:0]       flg,
    output logic [TAG_W-1:0] tag_out
);

    typedef enum logic [2:0] {
        MUL_LO_S = 3'd0,
        MUL_LO_U = 3'd1,
        MULH_UU  = 3'd2,
        MULH_SS  = 3'd3,
        MULH_SU  = 3'd4,
        MUL32_S  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    // Product width must hold both the 2*WIDTH product and the 64-bit MUL32 product.
    localparam int PW = (2 * WIDTH > 64) ? 2 * WIDTH : 64;
    localparam int HW = (WIDTH < 32) ? WIDTH : 32;
    localparam int DL = STAGES - 1;

    logic             s1_vld;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] res32;
    logic [WIDTH-1:0] res_c;
    logic             cf_c;
    logic             rsv_c;
    logic [5:0]       flg_c;

    logic             vld_q [0:DL-1];
    logic [WIDTH-1:0] res_q [0:DL-1];
    logic [5:0]       flg_q [0:DL-1];
    logic [TAG_W-1:0] tag_q [0:DL-1];

    // Operands are extended to PW bits so a single unsigned multiply yields the
    // correct two's-complement product modulo 2^PW for every sign combination.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        rsv_c = 1'b0;
        res_c = '0;
        cf_c  = 1'b0;
        res32 = '0;
        case (s1_op)
            MUL_LO_S, MULH_SS: begin
                a_ext = {{(PW-WIDTH){s1_a[WIDTH-1]}}, s1_a};
                b_ext = {{(PW-WIDTH){s1_b[WIDTH-1]}}, s1_b};
            end
            MUL_LO_U, MULH_UU: begin
                a_ext = PW'(s1_a);
                b_ext = PW'(s1_b);
            end
            MULH_SU: begin
                a_ext = {{(PW-WIDTH){s1_a[WIDTH-1]}}, s1_a};
                b_ext = PW'(s1_b);
            end
            MUL32_S: begin
                a_ext = {{(PW-HW){s1_a[HW-1]}}, s1_a[HW-1:0]};
                b_ext = {{(PW-HW){s1_b[HW-1]}}, s1_b[HW-1:0]};
            end
            default: rsv_c = 1'b1;
        endcase

        prod = a_ext * b_ext;
        p_hi = prod[2*WIDTH-1:WIDTH];
        for (int i = 0; i < WIDTH; i++) begin
            res32[i] = (i < 32) ? prod[i] : prod[31];
        end

        case (s1_op)
            MUL_LO_S: begin
                res_c = prod[WIDTH-1:0];
                cf_c  = (p_hi != {WIDTH{prod[WIDTH-1]}});
            end
            MUL_LO_U: begin
                res_c = prod[WIDTH-1:0];
                cf_c  = |p_hi;
            end
            MULH_UU, MULH_SS, MULH_SU: res_c = p_hi;
            MUL32_S: begin
                res_c = res32;
                cf_c  = (prod[63:32] != {32{prod[31]}});
            end
            default: res_c = '0;
        endcase

        flg_c = rsv_c ? 6'b0
                      : {cf_c, cf_c, 1'b0, res_c[WIDTH-1], (res_c == '0), ~^res_c[7:0]};
    end

    // Stage 1 captures the op; the remaining STAGES-1 registers carry the formatted
    // result so the output register is always the STAGES-th advancing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_op  <= MUL_LO_S;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
            for (int i = 0; i < DL; i++) begin
                vld_q[i] <= 1'b0;
                res_q[i] <= '0;
                flg_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            s1_vld <= 1'b0;
            for (int i = 0; i < DL; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else if (clkEn) begin
            s1_vld   <= in_vld;
            s1_op    <= op_e'(op);
            s1_a     <= A;
            s1_b     <= B;
            s1_tag   <= tag_in;
            vld_q[0] <= s1_vld;
            res_q[0] <= res_c;
            flg_q[0] <= flg_c;
            tag_q[0] <= s1_tag;
            for (int i = 1; i < DL; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
                flg_q[i] <= flg_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DL-1];
    assign Res     = res_q[DL-1];
    assign flg     = flg_q[DL-1];
    assign tag_out = tag_q[DL-1];

endmodule

// File: tb/tb_imul_pipe.sv
// Scoreboard bench for imul_pipe: a 64-bit/3-stage and a 32-bit/4-stage instance
// driven with directed vectors, checked by per-instance monitors.
module tb_imul_pipe;

    localparam logic [2:0] OP_LO_S = 3'd0, OP_LO_U = 3'd1, OP_H_UU = 3'd2,
                           OP_H_SS = 3'd3, OP_H_SU = 3'd4, OP_32_S = 3'd5;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  flg;
        logic [8:0]  tag;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clkEn, flush;
    logic        vld64, vld32;
    logic [2:0]  op64, op32;
    logic [63:0] a64, b64;
    logic [31:0] a32, b32;
    logic [8:0]  tag64, tag32;
    logic        out_vld64, out_vld32;
    logic [63:0] res64;
    logic [31:0] res32;
    logic [5:0]  flg64, flg32;
    logic [8:0]  tago64, tago32;

    exp_t sb64[$];
    exp_t sb32[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   adv_cnt  = 0;
    logic adv_last = 1'b0;

    imul_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(9)) dut64 (
        .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush), .in_vld(vld64),
        .op(op64), .A(a64), .B(b64), .tag_in(tag64), .out_vld(out_vld64),
        .Res(res64), .flg(flg64), .tag_out(tago64)
    );

    imul_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(9)) dut32 (
        .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush), .in_vld(vld32),
        .op(op32), .A(a32), .B(b32), .tag_in(tag32), .out_vld(out_vld32),
        .Res(res32), .flg(flg32), .tag_out(tago32)
    );

    always #5 clk = ~clk;

    // Count advancing edges so the monitors can check exact latency.
    always @(posedge clk) begin
        adv_last <= clkEn && !rst && !flush;
        if (clkEn && !rst && !flush) adv_cnt <= adv_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel32, input logic [2:0] o, input logic [63:0] a,
                                 input logic [63:0] b, input logic [8:0] t,
                                 input logic [63:0] er, input logic [5:0] ef, input bit push);
        exp_t e;
        e.res = er;
        e.flg = ef;
        e.tag = t;
        e.due = adv_cnt + (sel32 ? 4 : 3);
        if (sel32) begin
            vld32 = 1'b1; op32 = o; a32 = a[31:0]; b32 = b[31:0]; tag32 = t;
            if (push) sb32.push_back(e);
        end else begin
            vld64 = 1'b1; op64 = o; a64 = a; b64 = b; tag64 = t;
            if (push) sb64.push_back(e);
        end
        tick();
        vld64 = 1'b0;
        vld32 = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb64.size() != 0 || sb32.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", 64'(sb64.size() + sb32.size()), 64'd0);
    endtask

    // New results are popped only on edges that advanced the pipe, so a stalled
    // valid output is not counted twice.
    always @(negedge clk) begin
        exp_t e;
        if (out_vld64 && adv_last) begin
            if (sb64.size() == 0) begin
                checkOutput("unexpected_out64", 64'd1, 64'd0);
            end else begin
                e = sb64.pop_front();
                checkOutput("res64", res64, e.res);
                checkOutput("flg64", 64'(flg64), 64'(e.flg));
                checkOutput("tag64", 64'(tago64), 64'(e.tag));
                checkOutput("latency64", 64'(adv_cnt), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_vld32 && adv_last) begin
            if (sb32.size() == 0) begin
                checkOutput("unexpected_out32", 64'd1, 64'd0);
            end else begin
                e = sb32.pop_front();
                checkOutput("res32", 64'(res32), e.res);
                checkOutput("flg32", 64'(flg32), 64'(e.flg));
                checkOutput("tag32", 64'(tago32), 64'(e.tag));
                checkOutput("latency32", 64'(adv_cnt), 64'(e.due));
            end
        end
    end

    initial begin
        rst = 1'b1; clkEn = 1'b1; flush = 1'b0;
        vld64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; tag64 = '0;
        vld32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; tag32 = '0;
        repeat (2) tick();
        checkOutput("rst_vld", 64'(out_vld64), 64'd0);
        checkOutput("rst_res", res64, 64'd0);
        checkOutput("rst_flg", 64'(flg64), 64'd0);
        checkOutput("rst_tag", 64'(tago64), 64'd0);
        rst = 1'b0;

        applyStimulus(0, OP_LO_S, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 9'd1, 64'hFFFF_FFFF_FFFF_FFFE, 6'b000100, 1);
        applyStimulus(0, OP_H_UU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 9'd2, 64'h1, 6'b000000, 1);
        applyStimulus(0, OP_H_SS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 9'd3, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000101, 1);
        applyStimulus(0, OP_LO_U, 64'h8000_0000_0000_0000, 64'd4, 9'd4, 64'h0, 6'b110011, 1);
        applyStimulus(0, OP_H_SU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 9'd5, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000101, 1);
        applyStimulus(0, OP_32_S, 64'h4000_0000, 64'd4, 9'd6, 64'h0, 6'b110011, 1);
        applyStimulus(0, OP_32_S, 64'hFFFF_FFFD, 64'd5, 9'd7, 64'hFFFF_FFFF_FFFF_FFF1, 6'b000100, 1);
        applyStimulus(0, OP_LO_S, 64'h4000_0000_0000_0000, 64'd4, 9'd8, 64'h0, 6'b110011, 1);
        applyStimulus(0, OP_LO_U, 64'd3, 64'd5, 9'd9, 64'hF, 6'b000001, 1);
        applyStimulus(0, OP_H_SU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'd10, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000101, 1);
        applyStimulus(0, OP_H_UU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'd11, 64'hFFFF_FFFF_FFFF_FFFE, 6'b000100, 1);
        applyStimulus(0, OP_32_S, 64'hDEAD_BEEF_0000_0007, 64'h1234_5678_0000_0003, 9'd12, 64'h15, 6'b000000, 1);
        applyStimulus(0, 3'd6, 64'd3, 64'd5, 9'd13, 64'h0, 6'b000000, 1);
        applyStimulus(0, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'd14, 64'h0, 6'b000000, 1);
        waitDrain();

        // Stall while the op is mid-pipe: output must wait for the third advancing edge.
        applyStimulus(0, OP_LO_U, 64'd3, 64'd5, 9'd20, 64'hF, 6'b000001, 1);
        tick();
        clkEn = 1'b0;
        repeat (4) begin
            tick();
            checkOutput("stall_vld", 64'(out_vld64), 64'd0);
        end
        clkEn = 1'b1;
        waitDrain();

        // Stall while a valid result sits at the output: it must stay frozen.
        applyStimulus(0, OP_LO_S, 64'h4000_0000_0000_0000, 64'd4, 9'd21, 64'h0, 6'b110011, 1);
        applyStimulus(0, OP_H_SU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 9'd22, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000101, 1);
        tick();
        clkEn = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("frozen_vld", 64'(out_vld64), 64'd1);
            checkOutput("frozen_res", res64, 64'h0);
            checkOutput("frozen_flg", 64'(flg64), 64'(6'b110011));
            checkOutput("frozen_tag", 64'(tago64), 64'd21);
        end
        clkEn = 1'b1;
        waitDrain();

        // Flush with two ops in flight and a third presented in the flush cycle.
        applyStimulus(0, OP_LO_U, 64'd3, 64'd5, 9'd30, 64'hF, 6'b000001, 0);
        applyStimulus(0, OP_LO_U, 64'd7, 64'd9, 9'd31, 64'd63, 6'b000001, 0);
        flush = 1'b1; clkEn = 1'b0; vld64 = 1'b1; op64 = OP_LO_U; tag64 = 9'd32;
        tick();
        flush = 1'b0; clkEn = 1'b1; vld64 = 1'b0;
        repeat (5) begin
            tick();
            checkOutput("flush_vld", 64'(out_vld64), 64'd0);
        end

        // Reset mid-operation after a nonzero result has been presented.
        applyStimulus(0, OP_LO_U, 64'd3, 64'd5, 9'd40, 64'hF, 6'b000001, 1);
        waitDrain();
        applyStimulus(0, OP_LO_U, 64'd7, 64'd9, 9'd41, 64'd63, 6'b000001, 0);
        applyStimulus(0, OP_LO_U, 64'd2, 64'd9, 9'd42, 64'd18, 6'b000001, 0);
        rst = 1'b1; vld64 = 1'b1;
        tick();
        rst = 1'b0; vld64 = 1'b0;
        checkOutput("midrst_vld", 64'(out_vld64), 64'd0);
        checkOutput("midrst_res", res64, 64'd0);
        checkOutput("midrst_flg", 64'(flg64), 64'd0);
        checkOutput("midrst_tag", 64'(tago64), 64'd0);
        repeat (5) begin
            tick();
            checkOutput("midrst_quiet", 64'(out_vld64), 64'd0);
        end

        // 32-bit, 4-stage instance.
        applyStimulus(1, OP_LO_S, 64'hFFFF_FFFF, 64'd2, 9'd1, 64'hFFFF_FFFE, 6'b000100, 1);
        applyStimulus(1, OP_H_UU, 64'hFFFF_FFFF, 64'd2, 9'd2, 64'h1, 6'b000000, 1);
        applyStimulus(1, OP_H_SS, 64'hFFFF_FFFF, 64'd2, 9'd3, 64'hFFFF_FFFF, 6'b000101, 1);
        applyStimulus(1, OP_32_S, 64'hFFFF_FFFD, 64'd5, 9'd4, 64'hFFFF_FFF1, 6'b000100, 1);
        applyStimulus(1, OP_LO_U, 64'h8000_0000, 64'd4, 9'd5, 64'h0, 6'b110011, 1);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
